// File: rtl/stage_ex.sv
// Execute stage: operand forwarding, ALU, branch resolution and EX/MA pipeline register.
// Define EX_MUL_EN to build the 32-cycle shift-add multiplier FSM; without it MUL yields 0.
module stage_ex (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        i_ex_valid,
  input  logic        i_ex_flush,
  input  logic        i_ex_stall,
  input  logic [31:0] i_ex_PC,
  input  logic [31:0] i_ex_OP1,
  input  logic [31:0] i_ex_OP2,
  input  logic [31:0] i_ex_IM,
  input  logic [4:0]  i_ex_Rdst,
  input  logic [6:0]  i_ex_EX,
  input  logic [1:0]  i_ex_MA,
  input  logic [2:0]  i_ex_WB,
  input  logic [1:0]  i_OP1_ExS,
  input  logic [1:0]  i_OP2_ExS,
  input  logic [31:0] i_ex_fwd_ma,
  input  logic [31:0] i_ex_fwd_wb,
  output logic [31:0] o_ex_ALU_rslt,
  output logic [31:0] o_ex_Rs2_val,
  output logic [4:0]  o_ex_Rdst,
  output logic [31:0] o_ex_PC,
  output logic [1:0]  o_ex_MA,
  output logic [2:0]  o_ex_WB,
  output logic        o_ex_busy,
  output logic [31:0] o_ex_JmpAddr,
  output logic        o_ex_FlushPipeandPC
);

  logic [31:0] w_opa, w_op2, w_opb, w_alu;
  logic        w_idle, w_accept, w_start, w_load_alu, w_taken, w_mul_done;
  logic [31:0] w_mul_rslt, w_mul_pc;
  logic [4:0]  w_mul_rdst;
  logic [1:0]  w_mul_ma;
  logic [2:0]  w_mul_wb;

  always_comb begin
    case (i_OP1_ExS)
      2'b01:   w_opa = i_ex_fwd_ma;
      2'b10:   w_opa = i_ex_fwd_wb;
      default: w_opa = i_ex_OP1;
    endcase
    case (i_OP2_ExS)
      2'b01:   w_op2 = i_ex_fwd_ma;
      2'b10:   w_op2 = i_ex_fwd_wb;
      default: w_op2 = i_ex_OP2;
    endcase
    w_opb = i_ex_EX[4] ? i_ex_IM : w_op2;
  end

  // MUL (op 11) is never computed here; the FSM produces it when enabled.
  always_comb begin
    case (i_ex_EX[3:0])
      4'd0:    w_alu = w_opa + w_opb;
      4'd1:    w_alu = w_opa - w_opb;
      4'd2:    w_alu = w_opa & w_opb;
      4'd3:    w_alu = w_opa | w_opb;
      4'd4:    w_alu = w_opa ^ w_opb;
      4'd5:    w_alu = w_opa << w_opb[4:0];
      4'd6:    w_alu = w_opa >> w_opb[4:0];
      4'd7:    w_alu = $signed(w_opa) >>> w_opb[4:0];
      4'd8:    w_alu = {31'd0, $signed(w_opa) < $signed(w_opb)};
      4'd9:    w_alu = {31'd0, w_opa < w_opb};
      4'd10:   w_alu = w_opb;
      default: w_alu = 32'd0;
    endcase
  end

  assign w_taken    = i_ex_EX[5] & ((w_opa == w_op2) ^ i_ex_EX[6]);
  assign w_accept   = i_ex_valid & ~i_ex_stall & ~i_ex_flush & w_idle;
  assign w_load_alu = w_accept & ~w_start;

`ifdef EX_MUL_EN
  typedef enum logic [0:0] {StIdle, StMul} state_e;
  state_e      r_state, w_state_nxt;
  logic [4:0]  r_cnt;
  logic [31:0] r_mcand, r_mplier, r_prod, r_m_pc, w_prod_step;
  logic [4:0]  r_m_rdst;
  logic [1:0]  r_m_ma;
  logic [2:0]  r_m_wb;

  assign w_idle      = (r_state == StIdle);
  assign w_start     = w_accept & (i_ex_EX[3:0] == 4'd11);
  assign w_mul_done  = (r_state == StMul) & ~i_ex_flush & ~i_ex_stall & (r_cnt == 5'd31);
  assign w_prod_step = r_prod + (r_mplier[0] ? r_mcand : 32'd0);
  assign w_mul_rslt  = w_prod_step;
  assign w_mul_pc    = r_m_pc;
  assign w_mul_rdst  = r_m_rdst;
  assign w_mul_ma    = r_m_ma;
  assign w_mul_wb    = r_m_wb;

  always_ff @(posedge Clk) begin
    if (Rst) r_state <= StIdle;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle: if (w_start) w_state_nxt = StMul;
      StMul: begin
        if (i_ex_flush)      w_state_nxt = StIdle;
        else if (w_mul_done) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    o_ex_busy = (r_state == StMul);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_cnt    <= 5'd0;
      r_mcand  <= 32'd0;
      r_mplier <= 32'd0;
      r_prod   <= 32'd0;
      r_m_pc   <= 32'd0;
      r_m_rdst <= 5'd0;
      r_m_ma   <= 2'd0;
      r_m_wb   <= 3'd0;
    end else if (i_ex_flush) begin
      r_cnt <= 5'd0;
    end else if (!i_ex_stall) begin
      if (w_start) begin
        r_cnt    <= 5'd0;
        r_mcand  <= w_opa;
        r_mplier <= w_opb;
        r_prod   <= 32'd0;
        r_m_pc   <= i_ex_PC;
        r_m_rdst <= i_ex_Rdst;
        r_m_ma   <= i_ex_MA;
        r_m_wb   <= i_ex_WB;
      end else if (r_state == StMul) begin
        r_prod   <= w_prod_step;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 5'd1;
      end
    end
  end
`else
  assign w_idle     = 1'b1;
  assign w_start    = 1'b0;
  assign w_mul_done = 1'b0;
  assign w_mul_rslt = 32'd0;
  assign w_mul_pc   = 32'd0;
  assign w_mul_rdst = 5'd0;
  assign w_mul_ma   = 2'd0;
  assign w_mul_wb   = 3'd0;
  assign o_ex_busy  = 1'b0;
`endif

  // EX/MA register; anything that is not a completing instruction becomes an all-zero bubble.
  always_ff @(posedge Clk) begin
    if (Rst || i_ex_flush || (!i_ex_stall && !w_mul_done && !w_load_alu)) begin
      o_ex_ALU_rslt       <= 32'd0;
      o_ex_Rs2_val        <= 32'd0;
      o_ex_Rdst           <= 5'd0;
      o_ex_PC             <= 32'd0;
      o_ex_MA             <= 2'd0;
      o_ex_WB             <= 3'd0;
      o_ex_JmpAddr        <= 32'd0;
      o_ex_FlushPipeandPC <= 1'b0;
    end else if (!i_ex_stall && w_mul_done) begin
      o_ex_ALU_rslt       <= w_mul_rslt;
      o_ex_Rs2_val        <= 32'd0;
      o_ex_Rdst           <= w_mul_rdst;
      o_ex_PC             <= w_mul_pc;
      o_ex_MA             <= w_mul_ma;
      o_ex_WB             <= w_mul_wb;
      o_ex_JmpAddr        <= 32'd0;
      o_ex_FlushPipeandPC <= 1'b0;
    end else if (!i_ex_stall) begin
      o_ex_ALU_rslt       <= w_alu;
      o_ex_Rs2_val        <= w_op2;
      o_ex_Rdst           <= i_ex_Rdst;
      o_ex_PC             <= i_ex_PC;
      o_ex_MA             <= i_ex_MA;
      o_ex_WB             <= i_ex_WB;
      o_ex_JmpAddr        <= i_ex_PC + i_ex_IM;
      o_ex_FlushPipeandPC <= w_taken;
    end
  end

endmodule

// File: tb/tb_stage_ex.sv
// Self-checking bench for stage_ex: directed cases plus randomized ALU/branch traffic
// against a reference model. MUL timing checks apply when EX_MUL_EN is defined.
module tb_stage_ex;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        i_ex_valid, i_ex_flush, i_ex_stall;
  logic [31:0] i_ex_PC, i_ex_OP1, i_ex_OP2, i_ex_IM;
  logic [4:0]  i_ex_Rdst;
  logic [6:0]  i_ex_EX;
  logic [1:0]  i_ex_MA;
  logic [2:0]  i_ex_WB;
  logic [1:0]  i_OP1_ExS, i_OP2_ExS;
  logic [31:0] i_ex_fwd_ma, i_ex_fwd_wb;
  logic [31:0] o_ex_ALU_rslt, o_ex_Rs2_val, o_ex_PC, o_ex_JmpAddr;
  logic [4:0]  o_ex_Rdst;
  logic [1:0]  o_ex_MA;
  logic [2:0]  o_ex_WB;
  logic        o_ex_busy, o_ex_FlushPipeandPC;

  int n_checks = 0;
  int n_err    = 0;

  stage_ex dut (
    .Clk                 (Clk),
    .Rst                 (Rst),
    .i_ex_valid          (i_ex_valid),
    .i_ex_flush          (i_ex_flush),
    .i_ex_stall          (i_ex_stall),
    .i_ex_PC             (i_ex_PC),
    .i_ex_OP1            (i_ex_OP1),
    .i_ex_OP2            (i_ex_OP2),
    .i_ex_IM             (i_ex_IM),
    .i_ex_Rdst           (i_ex_Rdst),
    .i_ex_EX             (i_ex_EX),
    .i_ex_MA             (i_ex_MA),
    .i_ex_WB             (i_ex_WB),
    .i_OP1_ExS           (i_OP1_ExS),
    .i_OP2_ExS           (i_OP2_ExS),
    .i_ex_fwd_ma         (i_ex_fwd_ma),
    .i_ex_fwd_wb         (i_ex_fwd_wb),
    .o_ex_ALU_rslt       (o_ex_ALU_rslt),
    .o_ex_Rs2_val        (o_ex_Rs2_val),
    .o_ex_Rdst           (o_ex_Rdst),
    .o_ex_PC             (o_ex_PC),
    .o_ex_MA             (o_ex_MA),
    .o_ex_WB             (o_ex_WB),
    .o_ex_busy           (o_ex_busy),
    .o_ex_JmpAddr        (o_ex_JmpAddr),
    .o_ex_FlushPipeandPC (o_ex_FlushPipeandPC)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [31:0] model_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return a << sh;
      6:  return a >> sh;
      7:  return (a[31] ? ~(~a >> sh) : (a >> sh));
      8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      9:  return (a < b) ? 32'd1 : 32'd0;
      10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] model_fwd(input logic [1:0] sel, input logic [31:0] id,
                                            input logic [31:0] ma, input logic [31:0] wb);
    if (sel == 2'b01) return ma;
    if (sel == 2'b10) return wb;
    return id;
  endfunction

  task automatic issue(input int op, input logic useimm, input logic br, input logic bne,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                       input logic [31:0] pc, input logic [4:0] rd, input logic [1:0] ma,
                       input logic [2:0] wb);
    i_ex_valid = 1'b1;
    i_ex_EX    = {bne, br, useimm, 4'(op)};
    i_ex_OP1   = a;
    i_ex_OP2   = b;
    i_ex_IM    = imm;
    i_ex_PC    = pc;
    i_ex_Rdst  = rd;
    i_ex_MA    = ma;
    i_ex_WB    = wb;
    i_OP1_ExS  = 2'b00;
    i_OP2_ExS  = 2'b00;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".alu"}, o_ex_ALU_rslt, 32'd0);
    chk({tag, ".ma"}, 32'(o_ex_MA), 32'd0);
    chk({tag, ".wb"}, 32'(o_ex_WB), 32'd0);
    chk({tag, ".rd"}, 32'(o_ex_Rdst), 32'd0);
    chk({tag, ".pc"}, o_ex_PC, 32'd0);
    chk({tag, ".flush"}, 32'(o_ex_FlushPipeandPC), 32'd0);
    chk({tag, ".busy"}, 32'(o_ex_busy), 32'd0);
  endtask

  initial begin
    logic [31:0] a, b, imm, pc, fa, fb, opb, exp_r;
    logic [1:0]  s1, s2, ma;
    logic [2:0]  wb;
    logic [4:0]  rd;
    logic        useimm, br, bne;
    int          op, busy_cnt;

    Rst = 1'b1; i_ex_flush = 1'b0; i_ex_stall = 1'b0;
    i_ex_fwd_ma = 32'h0; i_ex_fwd_wb = 32'h0;
    issue(0, 1'b0, 1'b1, 1'b0, 32'd7, 32'd7, 32'h40, 32'h200, 5'd9, 2'd1, 3'd7);
    step(); step();
    chk_zero("reset");

    Rst = 1'b0; i_ex_valid = 1'b0;
    step();
    chk_zero("bubble");

    // ADD with negative immediate
    issue(0, 1'b1, 1'b0, 1'b0, 32'd5, 32'd0, 32'hFFFFFFF9, 32'h44, 5'd3, 2'd2, 3'd5);
    step();
    chk("add.rslt", o_ex_ALU_rslt, 32'hFFFFFFFE);
    chk("add.ma", 32'(o_ex_MA), 32'd2);
    chk("add.wb", 32'(o_ex_WB), 32'd5);
    chk("add.rd", 32'(o_ex_Rdst), 32'd3);
    chk("add.pc", o_ex_PC, 32'h44);

    // Stall freezes the EX/MA register even with a new valid instruction
    issue(1, 1'b0, 1'b0, 1'b0, 32'd100, 32'd1, 32'd0, 32'h48, 5'd4, 2'd0, 3'd1);
    i_ex_stall = 1'b1;
    step();
    chk("stall.rslt", o_ex_ALU_rslt, 32'hFFFFFFFE);
    chk("stall.rd", 32'(o_ex_Rdst), 32'd3);
    i_ex_stall = 1'b0;

    // SUB with OP1 forwarded from MA
    issue(1, 1'b0, 1'b0, 1'b0, 32'h55, 32'h11, 32'd0, 32'h50, 5'd6, 2'd0, 3'd1);
    i_OP1_ExS = 2'b01; i_ex_fwd_ma = 32'h10;
    step();
    chk("sub.fwdma", o_ex_ALU_rslt, 32'hFFFFFFFF);
    chk("sub.rs2", o_ex_Rs2_val, 32'h11);

    // SRA by 33 (uses low five bits)
    issue(7, 1'b1, 1'b0, 1'b0, 32'h80000000, 32'd0, 32'd33, 32'h54, 5'd7, 2'd0, 3'd1);
    step();
    chk("sra", o_ex_ALU_rslt, 32'hC0000000);

    // OP2 forwarded from WB
    issue(0, 1'b0, 1'b0, 1'b0, 32'd1, 32'h999, 32'd0, 32'h58, 5'd8, 2'd0, 3'd1);
    i_OP2_ExS = 2'b10; i_ex_fwd_wb = 32'h20;
    step();
    chk("add.fwdwb", o_ex_ALU_rslt, 32'h21);
    chk("rs2.fwdwb", o_ex_Rs2_val, 32'h20);

    // BEQ taken, flush pulse lasts one cycle
    issue(0, 1'b0, 1'b1, 1'b0, 32'd3, 32'd3, 32'h20, 32'h100, 5'd0, 2'd0, 3'd0);
    step();
    chk("beq.jmp", o_ex_JmpAddr, 32'h120);
    chk("beq.flush", 32'(o_ex_FlushPipeandPC), 32'd1);
    i_ex_valid = 1'b0;
    step();
    chk("beq.flush1cyc", 32'(o_ex_FlushPipeandPC), 32'd0);

    issue(0, 1'b0, 1'b1, 1'b1, 32'd3, 32'd3, 32'h20, 32'h100, 5'd0, 2'd0, 3'd0);
    step();
    chk("bne.noflush", 32'(o_ex_FlushPipeandPC), 32'd0);

    // Flush beats a valid instruction
    issue(0, 1'b0, 1'b0, 1'b0, 32'd3, 32'd4, 32'd0, 32'h60, 5'd5, 2'd1, 3'd2);
    i_ex_flush = 1'b1;
    step();
    chk_zero("flush");
    i_ex_flush = 1'b0;

    // MUL opcode
    issue(11, 1'b0, 1'b0, 1'b0, 32'h10000, 32'h10001, 32'd0, 32'h70, 5'd12, 2'd0, 3'd3);
`ifdef EX_MUL_EN
    step();
    i_ex_valid = 1'b0;
    busy_cnt = 0;
    while (o_ex_busy && busy_cnt < 100) begin
      busy_cnt++;
      if (busy_cnt == 5) chk("mul.bubble", 32'(o_ex_WB), 32'd0);
      step();
    end
    chk("mul.cycles", 32'(busy_cnt), 32'd32);
    chk("mul.rslt", o_ex_ALU_rslt, 32'h00010000);
    chk("mul.rd", 32'(o_ex_Rdst), 32'd12);
    chk("mul.wb", 32'(o_ex_WB), 32'd3);

    issue(11, 1'b0, 1'b0, 1'b0, 32'd12345, 32'd6789, 32'd0, 32'h74, 5'd13, 2'd0, 3'd3);
    step();
    busy_cnt = 0;
    while (o_ex_busy && busy_cnt < 100) begin
      busy_cnt++;
      // garbage on ID/EX while busy must be ignored
      issue(0, 1'b0, 1'b0, 1'b0, $urandom, $urandom, 32'd0, 32'h0, 5'd1, 2'd1, 3'd1);
      i_ex_stall = (busy_cnt >= 10 && busy_cnt < 13);
      step();
    end
    i_ex_stall = 1'b0; i_ex_valid = 1'b0;
    chk("mulstall.cycles", 32'(busy_cnt), 32'd35);
    chk("mulstall.rslt", o_ex_ALU_rslt, 32'd12345 * 32'd6789);

    issue(11, 1'b0, 1'b0, 1'b0, 32'd3, 32'd5, 32'd0, 32'h78, 5'd14, 2'd1, 3'd3);
    step();
    i_ex_valid = 1'b0;
    repeat (10) step();
    i_ex_flush = 1'b1;
    step();
    i_ex_flush = 1'b0;
    chk_zero("mulflush");

    issue(11, 1'b0, 1'b0, 1'b0, 32'd3, 32'd5, 32'd0, 32'h78, 5'd14, 2'd1, 3'd3);
    step();
    i_ex_valid = 1'b0;
    repeat (10) step();
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    chk_zero("mulrst");
    chk("mulrst.jmp", o_ex_JmpAddr, 32'd0);
`else
    step();
    chk("mul.off.rslt", o_ex_ALU_rslt, 32'd0);
    chk("mul.off.busy", 32'(o_ex_busy), 32'd0);
    chk("mul.off.wb", 32'(o_ex_WB), 32'd3);
`endif

    // Randomized single-cycle traffic
    for (int i = 0; i < 80; i++) begin
      op = int'($urandom_range(0, 15));
`ifdef EX_MUL_EN
      if (op == 11) op = 0;
`endif
      a = $urandom; b = $urandom; imm = $urandom; pc = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      useimm = 1'($urandom_range(0, 1));
      br  = ($urandom_range(0, 2) == 0);
      bne = 1'($urandom_range(0, 1));
      rd = 5'($urandom); ma = 2'($urandom); wb = 3'($urandom);
      s1 = 2'($urandom); s2 = 2'($urandom);
      issue(op, useimm, br, bne, a, b, imm, pc, rd, ma, wb);
      i_OP1_ExS = s1; i_OP2_ExS = s2;
      i_ex_fwd_ma = $urandom; i_ex_fwd_wb = $urandom;
      if ($urandom_range(0, 3) == 0) i_ex_fwd_ma = a;
      fa = model_fwd(s1, a, i_ex_fwd_ma, i_ex_fwd_wb);
      fb = model_fwd(s2, b, i_ex_fwd_ma, i_ex_fwd_wb);
      opb = useimm ? imm : fb;
      exp_r = model_alu(op, fa, opb);
      step();
      chk($sformatf("rnd%0d.op%0d", i, op), o_ex_ALU_rslt, exp_r);
      chk($sformatf("rnd%0d.rs2", i), o_ex_Rs2_val, fb);
      chk($sformatf("rnd%0d.rd", i), 32'(o_ex_Rdst), 32'(rd));
      chk($sformatf("rnd%0d.wb", i), 32'(o_ex_WB), 32'(wb));
      chk($sformatf("rnd%0d.flush", i), 32'(o_ex_FlushPipeandPC),
          32'(br && ((fa == fb) != bne)));
      if (br && ((fa == fb) != bne))
        chk($sformatf("rnd%0d.jmp", i), o_ex_JmpAddr, pc + imm);
    end

    i_ex_valid = 1'b0;
    step();
    chk("final.bubble.ma", 32'(o_ex_MA), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
